ship_move_ctrl: RTL
===================

Name: ship_move_ctrl

Overview:
Movement sequencer in front of the ship position register. Turns debounced left/right button levels into single-cycle step commands. Behaviour per press:
- one immediate step on press;
- then a hold-to-repeat cadence timed in frame ticks;
- simultaneous left/right presses resolved last-pressed-wins.

The downstream position block is advanced only by o_step_left / o_step_right, at most one position per pulse.

Parameters:
INITIAL_DELAY, 8, frame ticks between the press step and the first repeat step (legal range 1..2^CNT_W-1).
REPEAT_PERIOD, 4, frame ticks between consecutive repeat steps (legal range 1..2^CNT_W-1).
CNT_W, 6, width of the tick counter.
ACCEL_AFTER, 4, number of repeat steps before acceleration (used only with SHIP_CTRL_ACCEL_EN).

Ports:
i_clk_25MHz  input  1  system clock; all logic on its rising edge
i_reset  input  1  synchronous, active-low reset (0 = reset)
i_left_debounced  input  1  debounced left button level
i_right_debounced  input  1  debounced right button level
i_tick  input  1  one-cycle frame tick strobe
i_enable  input  1  game running; 0 suppresses all movement
o_step_left  output  1  one-cycle pulse: move ship one position left
o_step_right  output  1  one-cycle pulse: move ship one position right
o_active  output  1  1 when state is not IDLE
o_state  output  2  debug state encoding: IDLE=0, DELAY=1, REPEAT=2

Behaviour:
- Reset (i_reset==0 at a clock edge) has priority over everything, including mid-operation. State=IDLE, counter=0, dir=NONE, prev button regs=0. All outputs are 0 on the following cycle.
- All outputs are registered. o_step_left and o_step_right are never high together and are never high two consecutive cycles.
- Direction resolution, combinational from current levels plus prev-level regs:
  - only left high -> L; only right high -> R; neither -> NONE.
  - both high: the button that rose most recently wins.
  - both rise in the same cycle from both-low -> NONE, no step.
  - resolved dir is held until one button releases.
- IDLE: if i_enable and dir!=NONE, pulse the step for dir on the next cycle (latency 1 clock from the sampled press). Load counter=INITIAL_DELAY and go to DELAY.
- DELAY: on each i_tick:
  - counter==1 -> pulse step in current dir, load REPEAT_PERIOD, go to REPEAT;
  - otherwise decrement.
  - No change between ticks.
- REPEAT: on each i_tick:
  - counter==1 -> pulse step, reload REPEAT_PERIOD (or the accelerated period);
  - otherwise decrement.
- Direction change in DELAY/REPEAT (dir differs from latched dir and is not NONE): treated as a new press. Immediate step in the new dir on the next cycle, counter=INITIAL_DELAY, state=DELAY.
- Release (dir becomes NONE) in any state -> IDLE next cycle, no step, counter cleared.
- i_enable==0: no step pulses, state forced to IDLE, counter cleared. A button still held when i_enable rises counts as a new press (immediate step).
- A tick in the same cycle as a new press or direction change is ignored for counting.
- Counter arithmetic is unsigned CNT_W bits and never wraps, because reload happens at 1.
- No position knowledge: edge clamping is the position block's job. Steps are still issued at the ship's limits.

Optional Feature:
SHIP_CTRL_ACCEL_EN
- Defined:
  - An internal repeat-step counter (saturating, reset on entry to DELAY/IDLE) counts steps issued in REPEAT.
  - Once it reaches ACCEL_AFTER, reloads use max(REPEAT_PERIOD>>1, 1).
  - This takes effect from the reload that issues the ACCEL_AFTER-th repeat step, so the next interval is already the accelerated one.
- Not defined: reload is always REPEAT_PERIOD, ACCEL_AFTER is ignored, and no extra registers are present.

Test Plan:
- Defaults, i_tick every 10 clocks, i_enable=1, press left at cycle 0 and hold: o_step_left at cycle 1, then on the 8th tick, then every 4th tick; o_step_right stays 0.
- Hold left, then press right 3 ticks later: o_step_right one cycle after the right rise, and DELAY restarts (next right step 8 ticks later). Release right while left is still held: left latches as new dir and steps one cycle later.
- Left and right rise in the same cycle from both low: no step, o_active=0. Release left: right steps one cycle later.
- Hold right through 20 ticks, drop i_enable: no further pulses and o_state=0. Raise i_enable with right still held: o_step_right one cycle later.
- Assert i_reset=0 during REPEAT with a tick pending: next cycle outputs 0 and o_state=0. After release with right held: immediate step.
- SHIP_CTRL_ACCEL_EN defined, hold left 40 ticks:
  - steps at ticks 0, 8, 12, 16, 20, 24; the step at tick 24 is the 4th repeat;
  - then steps every 2 ticks (26, 28, ...);
  - without the macro, steps stay every 4 ticks.

Source files
------------

// File: rtl/ship_move_ctrl.sv
// Ship movement sequencer: turns debounced left/right levels into single-cycle step pulses
// with press step, hold-to-repeat cadence in frame ticks, last-pressed-wins. Optional: SHIP_CTRL_ACCEL_EN.
//
// state  | meaning
// IDLE   | no direction held or game disabled, counter cleared
// DELAY  | press step issued, counting INITIAL_DELAY ticks to the first repeat
// REPEAT | issuing a step every REPEAT_PERIOD ticks (halved after ACCEL_AFTER repeats when accelerated)
module ship_move_ctrl #(
   parameter int INITIAL_DELAY = 8,
   parameter int REPEAT_PERIOD = 4,
   parameter int CNT_W         = 6,
   parameter int ACCEL_AFTER   = 4
) (
   input  logic       i_clk_25MHz,
   input  logic       i_reset,
   input  logic       i_left_debounced,
   input  logic       i_right_debounced,
   input  logic       i_tick,
   input  logic       i_enable,
   output logic       o_step_left,
   output logic       o_step_right,
   output logic       o_active,
   output logic [1:0] o_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DELAY  = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_L    = 2'd1,
      DIR_R    = 2'd2
   } dir_t;

   localparam logic [CNT_W-1:0] C_INIT = CNT_W'(INITIAL_DELAY);
   localparam logic [CNT_W-1:0] C_REP  = CNT_W'(REPEAT_PERIOD);

   state_t            r_state;
   dir_t              r_dir_res;
   dir_t              r_mv_dir;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_left_prev;
   logic              r_right_prev;
   logic              r_step_l;
   logic              r_step_r;
   logic              r_active;

   logic              w_rise_l;
   logic              w_rise_r;
   dir_t              w_dir;
   logic              w_tick;
   logic [CNT_W-1:0]  w_reload;

   // Both held: the most recent riser wins; a simultaneous rise resolves to no direction,
   // and once resolved the choice sticks until one button is released.
   always_comb begin
      w_rise_l = i_left_debounced & ~r_left_prev;
      w_rise_r = i_right_debounced & ~r_right_prev;
      w_dir    = DIR_NONE;
      case ({i_left_debounced, i_right_debounced})
         2'b10:   w_dir = DIR_L;
         2'b01:   w_dir = DIR_R;
         2'b11: begin
            if (w_rise_l && w_rise_r)  w_dir = DIR_NONE;
            else if (w_rise_l)         w_dir = DIR_L;
            else if (w_rise_r)         w_dir = DIR_R;
            else                       w_dir = r_dir_res;
         end
         default: w_dir = DIR_NONE;
      endcase
   end

   // A tick landing while a step pulse is on the output is not counted, so the same
   // step line can never pulse on two consecutive cycles even with a 1-tick delay.
   assign w_tick = i_tick & ~(r_step_l | r_step_r);

`ifdef SHIP_CTRL_ACCEL_EN
   localparam int RW = (ACCEL_AFTER < 1) ? 1 : $clog2(ACCEL_AFTER + 1);
   localparam int FAST_I = ((REPEAT_PERIOD >> 1) < 1) ? 1 : (REPEAT_PERIOD >> 1);
   localparam logic [CNT_W-1:0] C_FAST = CNT_W'(FAST_I);

   logic [RW-1:0] r_rep_cnt;
   logic [RW-1:0] w_rep_nxt;

   always_comb begin
      w_rep_nxt = (r_rep_cnt >= RW'(ACCEL_AFTER)) ? r_rep_cnt : r_rep_cnt + RW'(1);
      w_reload  = (w_rep_nxt >= RW'(ACCEL_AFTER)) ? C_FAST : C_REP;
   end
`else
   assign w_reload = C_REP;
`endif

   always_ff @(posedge i_clk_25MHz) begin
      if (!i_reset) begin
         r_state      <= S_IDLE;
         r_dir_res    <= DIR_NONE;
         r_mv_dir     <= DIR_NONE;
         r_cnt        <= '0;
         r_left_prev  <= 1'b0;
         r_right_prev <= 1'b0;
         r_step_l     <= 1'b0;
         r_step_r     <= 1'b0;
         r_active     <= 1'b0;
`ifdef SHIP_CTRL_ACCEL_EN
         r_rep_cnt    <= '0;
`endif
      end else begin
         r_left_prev  <= i_left_debounced;
         r_right_prev <= i_right_debounced;
         r_dir_res    <= w_dir;
         r_step_l     <= 1'b0;
         r_step_r     <= 1'b0;
         if (!i_enable || w_dir == DIR_NONE) begin
            r_state   <= S_IDLE;
            r_active  <= 1'b0;
            r_mv_dir  <= DIR_NONE;
            r_cnt     <= '0;
`ifdef SHIP_CTRL_ACCEL_EN
            r_rep_cnt <= '0;
`endif
         end else if (r_state == S_IDLE || w_dir != r_mv_dir) begin
            r_step_l  <= (w_dir == DIR_L);
            r_step_r  <= (w_dir == DIR_R);
            r_mv_dir  <= w_dir;
            r_cnt     <= C_INIT;
            r_state   <= S_DELAY;
            r_active  <= 1'b1;
`ifdef SHIP_CTRL_ACCEL_EN
            r_rep_cnt <= '0;
`endif
         end else if (w_tick) begin
            if (r_cnt == CNT_W'(1)) begin
               r_step_l <= (r_mv_dir == DIR_L);
               r_step_r <= (r_mv_dir == DIR_R);
               if (r_state == S_DELAY) begin
                  r_cnt   <= C_REP;
                  r_state <= S_REPEAT;
               end else begin
                  r_cnt   <= w_reload;
`ifdef SHIP_CTRL_ACCEL_EN
                  r_rep_cnt <= w_rep_nxt;
`endif
               end
            end else begin
               r_cnt <= r_cnt - CNT_W'(1);
            end
         end
      end
   end

   assign o_step_left  = r_step_l;
   assign o_step_right = r_step_r;
   assign o_active     = r_active;
   assign o_state      = r_state;

endmodule
